// File: rtl/slow_tick_counter.sv
// Synchronises a divided clock as data, detects its edges and runs a
// two-digit BCD up/down counter under start/stop/clear control.
// Build option: define SLOW_TICK_BOTH_EDGES_EN to tick on both slow_in edges.
module slow_tick_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MODULO      = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up_dn,
  output logic       tick,
  output logic       wrap,
  output logic       running,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_TENS = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULO - 1) % 10);

  // BCD increment without range wrap; caller handles the MODULO-1 case.
  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o == 4'd9) begin
      r = {t + 4'd1, 4'd0};
    end else begin
      r = {t, o + 4'd1};
    end
    return r;
  endfunction

  // BCD decrement without range wrap; caller handles the 00 case.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o == 4'd0) begin
      r = {t - 4'd1, 4'd9};
    end else begin
      r = {t, o - 4'd1};
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   last_s;
  logic                   tick_s;

  state_t     state_r;
  state_t     state_s;
  logic       running_r;
  logic       wrap_r;
  logic       wrap_s;
  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic [3:0] tens_s;
  logic [3:0] ones_s;
  logic       count_en_s;
  logic       at_max_s;
  logic       at_zero_s;
  logic [7:0] inc_s;
  logic [7:0] dec_s;

  assign last_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain plus the previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], slow_in};
      prev_r <= last_s;
    end
  end

`ifdef SLOW_TICK_BOTH_EDGES_EN
  assign tick_s = last_s ^ prev_r;
`else
  assign tick_s = last_s & ~prev_r;
`endif

  assign tick = tick_s;

  // Run-control next-state: clear dominates, stop beats start.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (start && !stop) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PAUSED;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  assign at_max_s   = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
  assign at_zero_s  = (tens_r == 4'd0) && (ones_r == 4'd0);
  assign inc_s      = bcd_inc(tens_r, ones_r);
  assign dec_s      = bcd_dec(tens_r, ones_r);
  // A tick counts on the registered state, so a stop in the same cycle still counts it.
  assign count_en_s = tick_s && (state_r == ST_RUN) && !clear;

  // Next count value and wrap flag.
  always_comb begin
    tens_s = tens_r;
    ones_s = ones_r;
    wrap_s = 1'b0;
    if (clear) begin
      tens_s = 4'd0;
      ones_s = 4'd0;
    end else if (count_en_s) begin
      if (up_dn) begin
        if (at_max_s) begin
          tens_s = 4'd0;
          ones_s = 4'd0;
          wrap_s = 1'b1;
        end else begin
          tens_s = inc_s[7:4];
          ones_s = inc_s[3:0];
        end
      end else begin
        if (at_zero_s) begin
          tens_s = MAX_TENS;
          ones_s = MAX_ONES;
          wrap_s = 1'b1;
        end else begin
          tens_s = dec_s[7:4];
          ones_s = dec_s[3:0];
        end
      end
    end else begin
      wrap_s = 1'b0;
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
    end else begin
      state_r   <= state_s;
      running_r <= (state_s == ST_RUN);
      wrap_r    <= wrap_s;
      tens_r    <= tens_s;
      ones_r    <= ones_s;
    end
  end

  assign wrap    = wrap_r;
  assign running = running_r;
  assign tens    = tens_r;
  assign ones    = ones_r;

endmodule

// File: tb/tb_slow_tick_counter.sv
// Scoreboard bench: stimulus pushes the expected post-tick state, a monitor
// pops and compares one entry per observed tick pulse.
module tb_slow_tick_counter;

  logic clk = 1'b0;
  logic rst, slow_in, start, stop, clear, up_dn;
  logic tick, wrap, running;
  logic [3:0] tens, ones;
  logic tick100, wrap100, running100;
  logic [3:0] tens100, ones100;

  always #5 clk = ~clk;

  slow_tick_counter #(.SYNC_STAGES(2), .MODULO(60)) dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .start(start), .stop(stop),
    .clear(clear), .up_dn(up_dn), .tick(tick), .wrap(wrap),
    .running(running), .tens(tens), .ones(ones)
  );

  slow_tick_counter #(.SYNC_STAGES(2), .MODULO(100)) dut100 (
    .clk(clk), .rst(rst), .slow_in(slow_in), .start(start), .stop(stop),
    .clear(clear), .up_dn(up_dn), .tick(tick100), .wrap(wrap100),
    .running(running100), .tens(tens100), .ones(ones100)
  );

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic       w;
    logic       r;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   v = 0;
  int   v100 = 0;
  int   wc100_exp = 0;
  int   wc100_dut = 0;
  bit   run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int val);
    return {4'(val / 10), 4'(val % 10)};
  endfunction

  // Independent decimal model of one tick.
  task automatic model_tick();
    bit w;
    w = 1'b0;
    if (run) begin
      if (up_dn) begin
        w = (v == 59);
        v = (v + 1) % 60;
        if (v100 == 99) wc100_exp++;
        v100 = (v100 + 1) % 100;
      end else begin
        w = (v == 0);
        v = (v + 59) % 60;
        if (v100 == 0) wc100_exp++;
        v100 = (v100 + 99) % 100;
      end
    end
    q.push_back('{t: 4'(v / 10), o: 4'(v % 10), w: w, r: run});
  endtask

  task automatic period(input bit clr_on_tick);
    if (clr_on_tick) q.push_back('{t: 4'd0, o: 4'd0, w: 1'b0, r: 1'b0});
    else model_tick();
    slow_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tick_early", {31'd0, tick}, 32'd0);
    @(negedge clk);
    chk("tick_rise", {31'd0, tick}, 32'd1);
    if (clr_on_tick) begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      v = 0; v100 = 0; run = 1'b0;
      repeat (5) @(posedge clk);
    end else begin
      repeat (6) @(posedge clk);
    end
    #1;
`ifdef SLOW_TICK_BOTH_EDGES_EN
    model_tick();
`endif
    slow_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("dut100_count", {24'd0, tens100, ones100}, {24'd0, bcd(v100)});
    chk("dut100_wraps", wc100_dut, wc100_exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: one scoreboard entry per tick, plus pulse-width checks.
  initial begin
    exp_t e;
    bit tick_seen, wrap_seen;
    tick_seen = 1'b0;
    wrap_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (wrap100 === 1'b1) wc100_dut++;
      if (tick_seen) begin
        tests++;
        if (tick === 1'b1) begin
          fails++;
          $display("FAIL tick_width: tick high two cycles at %0t", $time);
        end
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tick: no expected entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("count_after_tick", {22'd0, tens, ones, wrap, running},
              {22'd0, e.t, e.o, e.w, e.r});
        end
      end
      if (wrap_seen) begin
        tests++;
        if (wrap === 1'b1) begin
          fails++;
          $display("FAIL wrap_width: wrap high two cycles at %0t", $time);
        end
      end
      tick_seen = (tick === 1'b1);
      wrap_seen = (wrap === 1'b1);
    end
  end

  initial begin
    rst = 1'b1; slow_in = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_state", {21'd0, tens, ones, running, wrap, tick}, 32'd0);
    end
    // slow_in already high at release: one tick, ignored in IDLE.
    q.push_back('{t: 4'd0, o: 4'd0, w: 1'b0, r: 1'b0});
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
`ifdef SLOW_TICK_BOTH_EDGES_EN
    model_tick();
`endif
    slow_in = 1'b0;
    repeat (8) @(posedge clk); #1;
    period(1'b0);
    period(1'b0);
    chk("idle_hold", {24'd0, tens, ones}, 32'd0);

    pulse_start();
    run = 1'b1;
    chk("running_after_start", {31'd0, running}, 32'd1);
    for (int i = 0; i < 100; i++) period(1'b0);

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    v = 0; v100 = 0; run = 1'b0;
    chk("clear_state", {23'd0, tens, ones, running}, 32'd0);
    pulse_start();
    run = 1'b1;
    up_dn = 1'b0;
    period(1'b0);
    period(1'b0);

    up_dn = 1'b1;
    for (int i = 0; i < 9; i++) period(1'b0);
    chk("reach_07", {24'd0, tens, ones}, {24'd0, bcd(v)});
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    run = 1'b0;
    chk("paused_running", {31'd0, running}, 32'd0);
    period(1'b0);
    period(1'b0);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("start_stop_paused", {31'd0, running}, 32'd0);
    period(1'b0);
    pulse_start();
    run = 1'b1;
    chk("resume_running", {31'd0, running}, 32'd1);
    period(1'b0);
    chk("resume_08", {24'd0, tens, ones}, {24'd0, bcd(v)});
    period(1'b1);
    chk("clear_on_tick", {23'd0, tens, ones, running}, 32'd0);

    pulse_start();
    run = 1'b1;
    for (int i = 0; i < 42; i++) period(1'b0);
    chk("before_reset", {24'd0, tens, ones}, {24'd0, bcd(v)});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v = 0; v100 = 0; run = 1'b0;
    chk("mid_reset", {22'd0, tens, ones, running, wrap}, 32'd0);
    period(1'b0);

    repeat (4) @(posedge clk); #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
